// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use, branch, dmem wait, halt/resume.
// Optional stall-cycle performance counter enabled by defining PIPE_CTRL_PERF_EN.
module pipe_hazard_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 64,
  parameter int unsigned STALL_CNT_W = 32
) (
  input  logic                   clk,
  input  logic                   arst_n,
  input  logic [4:0]             id_rs,
  input  logic [4:0]             id_rt,
  input  logic                   id_uses_rt,
  input  logic                   ex_mem_read,
  input  logic [4:0]             ex_reg_rd,
  input  logic                   ex_branch_taken,
  input  logic                   mem_dmem_req,
  input  logic                   dmem_ready,
  input  logic                   wb_halt,
  input  logic                   resume,
  output logic                   pc_en,
  output logic                   if_id_en,
  output logic                   if_id_flush,
  output logic                   id_ex_en,
  output logic                   id_ex_flush,
  output logic                   ex_mem_en,
  output logic                   mem_wb_en,
  output logic                   mem_wb_flush,
  output logic                   halted,
  output logic                   mem_err,
  output logic [STALL_CNT_W-1:0] stall_cycles
);

  localparam int unsigned WAIT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MEM_TIMEOUT);

  localparam logic [1:0] ST_RUN    = 2'd0;
  localparam logic [1:0] ST_DWAIT  = 2'd1;
  localparam logic [1:0] ST_HALTED = 2'd2;

  logic [1:0]        state;
  logic [1:0]        state_nxt;
  logic [WAIT_W-1:0] wait_cnt;
  logic [WAIT_W-1:0] wait_cnt_nxt;
  logic              resume_q;
  logic              freeze;
  logic              load_use;
  logic              halt_req;

  assign freeze   = mem_dmem_req & ~dmem_ready;
  assign load_use = ex_mem_read & (ex_reg_rd != 5'd0) &
                    ((ex_reg_rd == id_rs) | (id_uses_rt & (ex_reg_rd == id_rt)));
  // The halt has already left WB in the cycle after resume, so a stale wb_halt is ignored.
  assign halt_req = wb_halt & ~resume_q;
  assign halted   = (state == ST_HALTED);

  // Next state and zero-latency strobes.
  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    pc_en        = 1'b1;
    if_id_en     = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_en     = 1'b1;
    id_ex_flush  = 1'b0;
    ex_mem_en    = 1'b1;
    mem_wb_en    = 1'b1;
    mem_wb_flush = 1'b0;

    case (state)
      ST_HALTED: begin
        wait_cnt_nxt = '0;
        if (resume) begin
          state_nxt = ST_RUN;
        end else begin
          pc_en     = 1'b0;
          if_id_en  = 1'b0;
          id_ex_en  = 1'b0;
          ex_mem_en = 1'b0;
          mem_wb_en = 1'b0;
        end
      end
      default: begin
        if (freeze) begin
          state_nxt    = ST_DWAIT;
          pc_en        = 1'b0;
          if_id_en     = 1'b0;
          id_ex_en     = 1'b0;
          ex_mem_en    = 1'b0;
          mem_wb_flush = 1'b1;
          if (state != ST_DWAIT) begin
            wait_cnt_nxt = WAIT_W'(1);
          end else if (wait_cnt != WAIT_MAX) begin
            wait_cnt_nxt = wait_cnt + WAIT_W'(1);
          end
        end else begin
          state_nxt    = ST_RUN;
          wait_cnt_nxt = '0;
          if (halt_req) begin
            // Stop every register so the halt instruction stays parked in WB.
            state_nxt = ST_HALTED;
            pc_en     = 1'b0;
            if_id_en  = 1'b0;
            id_ex_en  = 1'b0;
            ex_mem_en = 1'b0;
            mem_wb_en = 1'b0;
          end else if (ex_branch_taken) begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
          end else if (load_use) begin
            pc_en       = 1'b0;
            if_id_en    = 1'b0;
            id_ex_flush = 1'b1;
          end
        end
      end
    endcase

    if (!arst_n) begin
      pc_en        = 1'b0;
      if_id_en     = 1'b0;
      id_ex_en     = 1'b0;
      ex_mem_en    = 1'b0;
      mem_wb_en    = 1'b0;
      if_id_flush  = 1'b1;
      id_ex_flush  = 1'b1;
      mem_wb_flush = 1'b1;
    end
  end

  // State, wait counter and sticky timeout flag.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state    <= ST_RUN;
      wait_cnt <= '0;
      mem_err  <= 1'b0;
      resume_q <= 1'b0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
      resume_q <= (state == ST_HALTED) & resume;
      if (wait_cnt_nxt == WAIT_MAX) begin
        mem_err <= 1'b1;
      end
    end
  end

`ifdef PIPE_CTRL_PERF_EN
  // Saturating count of cycles in which the PC was held.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      stall_cycles <= '0;
    end else if (!pc_en && (stall_cycles != {STALL_CNT_W{1'b1}})) begin
      stall_cycles <= stall_cycles + STALL_CNT_W'(1);
    end
  end
`else
  assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed-vector bench for pipe_hazard_ctrl; strobes checked as an 8-bit vector
// {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en, mem_wb_en, mem_wb_flush}.
module tb_pipe_hazard_ctrl;

  localparam logic [7:0] V_RUN    = 8'b1101_0110;
  localparam logic [7:0] V_RESET  = 8'b0010_1001;
  localparam logic [7:0] V_FREEZE = 8'b0000_0011;
  localparam logic [7:0] V_BRANCH = 8'b1111_1110;
  localparam logic [7:0] V_LDUSE  = 8'b0001_1110;
  localparam logic [7:0] V_HALT   = 8'b0000_0000;

  logic        clk = 1'b0;
  logic        arst_n;
  logic [4:0]  id_rs, id_rt, ex_reg_rd;
  logic        id_uses_rt, ex_mem_read, ex_branch_taken;
  logic        mem_dmem_req, dmem_ready, wb_halt, resume;
  logic        pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush;
  logic        ex_mem_en, mem_wb_en, mem_wb_flush, halted, mem_err;
  logic [31:0] stall_cycles;
  logic [7:0]  obs;

  int vecs = 0;
  int errs = 0;

  assign obs = {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush,
                ex_mem_en, mem_wb_en, mem_wb_flush};

  pipe_hazard_ctrl #(.MEM_TIMEOUT(4), .STALL_CNT_W(32)) dut (
    .clk(clk), .arst_n(arst_n),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .ex_mem_read(ex_mem_read), .ex_reg_rd(ex_reg_rd),
    .ex_branch_taken(ex_branch_taken),
    .mem_dmem_req(mem_dmem_req), .dmem_ready(dmem_ready),
    .wb_halt(wb_halt), .resume(resume),
    .pc_en(pc_en), .if_id_en(if_id_en), .if_id_flush(if_id_flush),
    .id_ex_en(id_ex_en), .id_ex_flush(id_ex_flush),
    .ex_mem_en(ex_mem_en), .mem_wb_en(mem_wb_en), .mem_wb_flush(mem_wb_flush),
    .halted(halted), .mem_err(mem_err), .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic clr_inputs();
    id_rs = 5'd0; id_rt = 5'd0; id_uses_rt = 1'b0;
    ex_mem_read = 1'b0; ex_reg_rd = 5'd0; ex_branch_taken = 1'b0;
    mem_dmem_req = 1'b0; dmem_ready = 1'b0; wb_halt = 1'b0; resume = 1'b0;
  endtask

  task automatic do_reset();
    clr_inputs();
    arst_n = 1'b0;
    #3;
    arst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    clr_inputs();
    arst_n = 1'b0;
    #12;
    vecs++;
    if (obs !== V_RESET) begin
      $display("FAIL reset_strobes: got %b want %b", obs, V_RESET); errs++;
    end
    vecs++;
    if ({halted, mem_err, stall_cycles} !== 34'd0) begin
      $display("FAIL reset_state: halted=%b mem_err=%b stall=%0d want 0/0/0",
               halted, mem_err, stall_cycles); errs++;
    end
    arst_n = 1'b1;
    tick();
    #1;
    vecs++;
    if (obs !== V_RUN) begin
      $display("FAIL idle_run: got %b want %b", obs, V_RUN); errs++;
    end
  endtask

  task automatic test_load_use();
    do_reset();
    ex_mem_read = 1'b1; ex_reg_rd = 5'd8; id_rs = 5'd8;
    #1;
    vecs++;
    if (obs !== V_LDUSE) begin
      $display("FAIL load_use_rs: got %b want %b", obs, V_LDUSE); errs++;
    end
    tick();
    ex_mem_read = 1'b0; ex_reg_rd = 5'd9; id_rs = 5'd1;
    #1;
    vecs++;
    if (obs !== V_RUN) begin
      $display("FAIL load_use_release: got %b want %b", obs, V_RUN); errs++;
    end
    ex_mem_read = 1'b1; ex_reg_rd = 5'd12; id_rs = 5'd3; id_rt = 5'd12; id_uses_rt = 1'b1;
    #1;
    vecs++;
    if (obs !== V_LDUSE) begin
      $display("FAIL load_use_rt: got %b want %b", obs, V_LDUSE); errs++;
    end
    id_uses_rt = 1'b0;
    #1;
    vecs++;
    if (obs !== V_RUN) begin
      $display("FAIL rt_not_used: got %b want %b", obs, V_RUN); errs++;
    end
    ex_reg_rd = 5'd0; id_rs = 5'd0; id_rt = 5'd0; id_uses_rt = 1'b1;
    #1;
    vecs++;
    if (obs !== V_RUN) begin
      $display("FAIL load_rd_zero: got %b want %b", obs, V_RUN); errs++;
    end
    clr_inputs();
  endtask

  task automatic test_dmem_wait();
    logic [31:0] exp_stall;
    do_reset();
    mem_dmem_req = 1'b1; dmem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      vecs++;
      if (obs !== V_FREEZE) begin
        $display("FAIL dmem_freeze[%0d]: got %b want %b", i, obs, V_FREEZE); errs++;
      end
      tick();
    end
    dmem_ready = 1'b1;
    #1;
    vecs++;
    if (obs !== V_RUN) begin
      $display("FAIL dmem_ready_cycle: got %b want %b", obs, V_RUN); errs++;
    end
    tick();
    mem_dmem_req = 1'b0; dmem_ready = 1'b0;
    #1;
`ifdef PIPE_CTRL_PERF_EN
    exp_stall = 32'd3;
`else
    exp_stall = 32'd0;
`endif
    vecs++;
    if ({mem_err, stall_cycles} !== {1'b0, exp_stall}) begin
      $display("FAIL dmem_counters: mem_err=%b stall=%0d want 0/%0d",
               mem_err, stall_cycles, exp_stall); errs++;
    end
  endtask

  task automatic test_timeout();
    do_reset();
    mem_dmem_req = 1'b1; dmem_ready = 1'b0;
    tick(); tick(); tick();
    #1;
    vecs++;
    if (mem_err !== 1'b0) begin
      $display("FAIL timeout_early: mem_err=%b want 0", mem_err); errs++;
    end
    tick();
    #1;
    vecs++;
    if ({mem_err, obs} !== {1'b1, V_FREEZE}) begin
      $display("FAIL timeout_hit: mem_err=%b strobes=%b want 1/%b", mem_err, obs, V_FREEZE); errs++;
    end
    tick(); tick();
    dmem_ready = 1'b1;
    #1;
    vecs++;
    if (obs !== V_RUN) begin
      $display("FAIL timeout_release: got %b want %b", obs, V_RUN); errs++;
    end
    tick();
    clr_inputs();
    tick();
    vecs++;
    if (mem_err !== 1'b1) begin
      $display("FAIL timeout_sticky: mem_err=%b want 1", mem_err); errs++;
    end
    arst_n = 1'b0;
    #1;
    vecs++;
    if ({mem_err, obs} !== {1'b0, V_RESET}) begin
      $display("FAIL timeout_reset: mem_err=%b strobes=%b want 0/%b", mem_err, obs, V_RESET); errs++;
    end
    #2;
    arst_n = 1'b1;
    tick();
  endtask

  task automatic test_branch();
    do_reset();
    ex_branch_taken = 1'b1; ex_mem_read = 1'b1; ex_reg_rd = 5'd8; id_rs = 5'd8;
    #1;
    vecs++;
    if (obs !== V_BRANCH) begin
      $display("FAIL branch_over_load_use: got %b want %b", obs, V_BRANCH); errs++;
    end
    tick();
    mem_dmem_req = 1'b1; dmem_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #1;
      vecs++;
      if (obs !== V_FREEZE) begin
        $display("FAIL branch_frozen[%0d]: got %b want %b", i, obs, V_FREEZE); errs++;
      end
      tick();
    end
    dmem_ready = 1'b1;
    #1;
    vecs++;
    if (obs !== V_BRANCH) begin
      $display("FAIL branch_after_freeze: got %b want %b", obs, V_BRANCH); errs++;
    end
    tick();
    clr_inputs();
    #1;
    vecs++;
    if (obs !== V_RUN) begin
      $display("FAIL branch_done: got %b want %b", obs, V_RUN); errs++;
    end
  endtask

  task automatic test_halt_resume();
    logic [31:0] exp_stall;
    do_reset();
    wb_halt = 1'b1;
    #1;
    vecs++;
    if ({halted, obs} !== {1'b0, V_HALT}) begin
      $display("FAIL halt_entry: halted=%b strobes=%b want 0/%b", halted, obs, V_HALT); errs++;
    end
    tick();
    for (int i = 0; i < 5; i++) begin
      #1;
      vecs++;
      if ({halted, obs} !== {1'b1, V_HALT}) begin
        $display("FAIL halted[%0d]: halted=%b strobes=%b want 1/%b", i, halted, obs, V_HALT); errs++;
      end
      tick();
    end
    resume = 1'b1;
    #1;
    vecs++;
    if ({halted, obs} !== {1'b1, V_RUN}) begin
      $display("FAIL resume_cycle: halted=%b strobes=%b want 1/%b", halted, obs, V_RUN); errs++;
    end
    tick();
    resume = 1'b0;
    #1;
    vecs++;
    if ({halted, obs} !== {1'b0, V_RUN}) begin
      $display("FAIL post_resume: halted=%b strobes=%b want 0/%b", halted, obs, V_RUN); errs++;
    end
    tick();
    wb_halt = 1'b0; resume = 1'b1;
    #1;
`ifdef PIPE_CTRL_PERF_EN
    exp_stall = 32'd6;
`else
    exp_stall = 32'd0;
`endif
    vecs++;
    if ({halted, obs, stall_cycles} !== {1'b0, V_RUN, exp_stall}) begin
      $display("FAIL resume_in_run: halted=%b strobes=%b stall=%0d want 0/%b/%0d",
               halted, obs, stall_cycles, V_RUN, exp_stall); errs++;
    end
    tick();
    clr_inputs();
    wb_halt = 1'b1;
    tick(); tick();
    arst_n = 1'b0;
    #1;
    vecs++;
    if ({halted, obs} !== {1'b0, V_RESET}) begin
      $display("FAIL reset_mid_halt: halted=%b strobes=%b want 0/%b", halted, obs, V_RESET); errs++;
    end
    wb_halt = 1'b0;
    #2;
    arst_n = 1'b1;
    tick();
    #1;
    vecs++;
    if ({halted, obs} !== {1'b0, V_RUN}) begin
      $display("FAIL run_after_reset: halted=%b strobes=%b want 0/%b", halted, obs, V_RUN); errs++;
    end
  endtask

  initial begin
    clr_inputs();
    arst_n = 1'b0;
    test_reset();
    test_load_use();
    test_dmem_wait();
    test_timeout();
    test_branch();
    test_halt_resume();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
